// File: rtl/kat_adc_pkg.sv
// Shared types and helpers for the KAT ADC sync aligner.
// Defaults here size the rotator when it is used on its own.
package kat_adc_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int unsigned MAX_SPC = 32;
  localparam int unsigned DEF_SPC = 4;
  localparam int unsigned PH_W    = $clog2(DEF_SPC);

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_edge_idx(input logic [MAX_SPC-1:0] edges);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SPC; i++) begin
      if (edges[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/kat_adc_sample_rotator.sv
// Combinational two-word-to-one rotation of one channel's samples.
// Output sample j is sample (phase + j) of the concatenation {nxt_word, cur_word}.
module kat_adc_sample_rotator
  import kat_adc_pkg::*;
#(
  parameter int unsigned SPC      = DEF_SPC,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned PHASE_W  = PH_W
) (
  input  logic [SPC*SAMPLE_W-1:0] cur_word,
  input  logic [SPC*SAMPLE_W-1:0] nxt_word,
  input  logic [PHASE_W-1:0]      phase,
  output logic [SPC*SAMPLE_W-1:0] rot_word_c
);

  logic [2*SPC*SAMPLE_W-1:0] pair;

  always_comb begin
    pair       = {nxt_word, cur_word};
    rot_word_c = '0;
    for (int unsigned j = 0; j < SPC; j++) begin
      rot_word_c[j*SAMPLE_W +: SAMPLE_W] = pair[(j + 32'(phase))*SAMPLE_W +: SAMPLE_W];
    end
  end

endmodule

// File: rtl/kat_adc_sync_aligner.sv
// ADC sync phase detector/locker and sample-stream realigner.
// Holds the FSM, period and error counters, the previous input word and the output register.
module kat_adc_sync_aligner
  import kat_adc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SPC        = 4,
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                             ctrl_clk_in,
  input  logic                             ctrl_reset_n,
  input  logic                             in_valid,
  input  logic [NUM_CH*SPC*SAMPLE_W-1:0]   in_data,
  input  logic [SPC-1:0]                   in_sync,
  input  logic [NUM_CH-1:0]                in_ovr,
  input  logic                             ovr_clear,
  input  logic                             err_clear,
  output logic                             out_valid,
  output logic [NUM_CH*SPC*SAMPLE_W-1:0]   out_data,
  output logic                             out_sync,
  output logic                             locked,
  output logic [$clog2(SPC)-1:0]           phase,
  output logic                             sync_err,
  output logic [ERR_W-1:0]                 sync_err_cnt,
  output logic [NUM_CH-1:0]                ovr_flag
);

  localparam int unsigned PHASE_W = $clog2(SPC);
  localparam int unsigned CH_W    = SPC * SAMPLE_W;
  localparam int unsigned DATA_W  = NUM_CH * CH_W;
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [TIMEOUT_W-1:0] PER_MAX = '1;
  localparam logic [ERR_W-1:0]     ERR_MAX = '1;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [TIMEOUT_W-1:0] per_q, per_d;
  logic                 prev_last_q, prev_last_d;
  logic [DATA_W-1:0]    prev_data_q, prev_data_d;
  logic                 prev_edge_q, prev_edge_d;
  logic                 have_prev_q, have_prev_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_sync_q, out_sync_d;
  logic                 locked_q, locked_d;
  logic                 sync_err_q, sync_err_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic [NUM_CH-1:0]    ovr_q, ovr_d;

  // Sample-granular rising edge; slot 0 looks back at the last sample of the previous word.
  logic [SPC-1:0]     edges_c;
  logic               edge_found_c;
  logic [PHASE_W-1:0] edge_idx_c;
  logic [DATA_W-1:0]  rot_c;

  assign edges_c      = in_sync & ~{in_sync[SPC-2:0], prev_last_q};
  assign edge_found_c = |edges_c;
  assign edge_idx_c   = PHASE_W'(lowest_edge_idx(MAX_SPC'(edges_c)));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    kat_adc_sample_rotator #(
      .SPC      (SPC),
      .SAMPLE_W (SAMPLE_W),
      .PHASE_W  (PHASE_W)
    ) u_rot (
      .cur_word   (prev_data_q[c*CH_W +: CH_W]),
      .nxt_word   (in_data[c*CH_W +: CH_W]),
      .phase      (phase_q),
      .rot_word_c (rot_c[c*CH_W +: CH_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    match_d     = match_q;
    per_d       = per_q;
    prev_last_d = prev_last_q;
    prev_data_d = prev_data_q;
    prev_edge_d = prev_edge_q;
    have_prev_d = have_prev_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sync_d  = 1'b0;
    sync_err_d  = 1'b0;

    if (in_valid) begin
      prev_last_d = in_sync[SPC-1];
      prev_data_d = in_data;
      prev_edge_d = edge_found_c;
      have_prev_d = 1'b1;

      if (edge_found_c) begin
        per_d = TIMEOUT_W'(1);
      end else if (per_q != PER_MAX) begin
        per_d = per_q + TIMEOUT_W'(1);
      end

      unique case (state_q)
        SEARCH: begin
          if (edge_found_c) begin
            state_d = ACQUIRE;
            phase_d = edge_idx_c;
            match_d = '0;
          end
        end
        ACQUIRE: begin
          if (edge_found_c) begin
            if (edge_idx_c == phase_q) begin
              match_d = match_q + MATCH_W'(1);
              if (match_q == MATCH_W'(LOCK_COUNT - 1)) state_d = LOCKED;
            end else begin
              phase_d = edge_idx_c;
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (edge_found_c && (edge_idx_c != phase_q)) begin
            sync_err_d = 1'b1;
            state_d    = ACQUIRE;
            phase_d    = edge_idx_c;
            match_d    = '0;
          end else if (!edge_found_c && (per_d == PER_MAX)) begin
            sync_err_d = 1'b1;
            state_d    = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase

      // The word straddling a phase change is dropped so no sample appears twice.
      out_valid_d = have_prev_q && (phase_d == phase_q);
      out_sync_d  = out_valid_d && prev_edge_q;
      if (out_valid_d) out_data_d = rot_c;
    end

    locked_d = (state_d == LOCKED);

    err_cnt_d = err_cnt_q;
    if (err_clear) begin
      err_cnt_d = sync_err_d ? ERR_W'(1) : '0;
    end else if (sync_err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    ovr_d = (ovr_q & ~{NUM_CH{ovr_clear}}) | (in_ovr & {NUM_CH{in_valid}});
  end

  always_ff @(posedge ctrl_clk_in or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= SEARCH;
      phase_q     <= '0;
      match_q     <= '0;
      per_q       <= '0;
      prev_last_q <= 1'b0;
      prev_data_q <= '0;
      prev_edge_q <= 1'b0;
      have_prev_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sync_q  <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      match_q     <= match_d;
      per_q       <= per_d;
      prev_last_q <= prev_last_d;
      prev_data_q <= prev_data_d;
      prev_edge_q <= prev_edge_d;
      have_prev_q <= have_prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sync_q  <= out_sync_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      err_cnt_q   <= err_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sync     = out_sync_q;
  assign locked       = locked_q;
  assign phase        = phase_q;
  assign sync_err     = sync_err_q;
  assign sync_err_cnt = err_cnt_q;
  assign ovr_flag     = ovr_q;

endmodule

// File: tb/tb_kat_adc_sync_aligner.sv
// Directed + randomized bench for kat_adc_sync_aligner against a flat-sample-stream reference model.
module tb_kat_adc_sync_aligner;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned SPC        = 4;
  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned LOCK_COUNT = 4;
  localparam int unsigned TIMEOUT_W  = 8;
  localparam int unsigned ERR_W      = 8;
  localparam int unsigned DW         = NUM_CH * SPC * SAMPLE_W;
  localparam int          TMAX       = (1 << TIMEOUT_W) - 1;
  localparam int          EMAX       = (1 << ERR_W) - 1;
  localparam int          S_SEARCH = 0, S_ACQ = 1, S_LOCK = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic [DW-1:0]       in_data = '0;
  logic [SPC-1:0]      in_sync = '0;
  logic [NUM_CH-1:0]   in_ovr = '0;
  logic                ovr_clear = 1'b0;
  logic                err_clear = 1'b0;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_sync;
  logic                locked;
  logic [1:0]          phase;
  logic                sync_err;
  logic [ERR_W-1:0]    sync_err_cnt;
  logic [NUM_CH-1:0]   ovr_flag;

  kat_adc_sync_aligner #(
    .NUM_CH(NUM_CH), .SPC(SPC), .SAMPLE_W(SAMPLE_W),
    .LOCK_COUNT(LOCK_COUNT), .TIMEOUT_W(TIMEOUT_W), .ERR_W(ERR_W)
  ) dut (
    .ctrl_clk_in  (clk),
    .ctrl_reset_n (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sync      (in_sync),
    .in_ovr       (in_ovr),
    .ovr_clear    (ovr_clear),
    .err_clear    (err_clear),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sync     (out_sync),
    .locked       (locked),
    .phase        (phase),
    .sync_err     (sync_err),
    .sync_err_cnt (sync_err_cnt),
    .ovr_flag     (ovr_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the input is a flat stream of samples; words are kept whole.
  logic [DW-1:0] m_words[$];
  int            m_ph[$];
  bit            m_edge[$];
  bit            m_prev_sync;
  int            m_state, m_phase, m_match, m_since;
  bit            e_vld, e_sync, e_err, e_locked;
  logic [DW-1:0] e_data;
  int            e_phase, e_cnt;
  logic [NUM_CH-1:0] e_ovr;

  bit gaps = 0;
  bit rnd_data = 0;
  bit ramp_chk = 0;
  int rv = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_words.delete(); m_ph.delete(); m_edge.delete();
    m_prev_sync = 0; m_state = S_SEARCH; m_phase = 0; m_match = 0; m_since = 0;
    e_vld = 0; e_sync = 0; e_err = 0; e_locked = 0; e_data = '0;
    e_phase = 0; e_cnt = 0; e_ovr = '0;
  endtask

  task automatic model_step(input bit v, input logic [SPC-1:0] sy, input logic [DW-1:0] d,
                            input logic [NUM_CH-1:0] ov, input bit oc, input bit ec);
    int k;
    bit prev;
    int n, base, f;
    logic [DW-1:0] w;
    k = -1;
    e_vld = 0; e_sync = 0; e_err = 0;
    if (v) begin
      prev = m_prev_sync;
      for (int s = 0; s < SPC; s++) begin
        if (sy[s] && !prev && k < 0) k = s;
        prev = sy[s];
      end
      m_prev_sync = sy[SPC-1];
      if (k >= 0) m_since = 1;
      else if (m_since < TMAX) m_since++;
      case (m_state)
        S_SEARCH: if (k >= 0) begin m_state = S_ACQ; m_phase = k; m_match = 0; end
        S_ACQ: if (k >= 0) begin
          if (k == m_phase) begin
            m_match++;
            if (m_match == LOCK_COUNT) m_state = S_LOCK;
          end else begin
            m_phase = k; m_match = 0;
          end
        end
        default: begin
          if (k >= 0 && k != m_phase) begin
            e_err = 1; m_state = S_ACQ; m_phase = k; m_match = 0;
          end else if (k < 0 && m_since == TMAX) begin
            e_err = 1; m_state = S_SEARCH;
          end
        end
      endcase
      m_words.push_back(d); m_ph.push_back(m_phase); m_edge.push_back(k >= 0);
      n = m_words.size() - 1;
      if (n >= 1 && m_ph[n] == m_ph[n-1]) begin
        e_vld = 1;
        e_sync = m_edge[n-1];
        base = (n - 1) * SPC + m_ph[n-1];
        for (int c = 0; c < NUM_CH; c++) begin
          for (int j = 0; j < SPC; j++) begin
            f = base + j;
            w = m_words[f / SPC];
            e_data[(c*SPC+j)*SAMPLE_W +: SAMPLE_W] = w[(c*SPC + f % SPC)*SAMPLE_W +: SAMPLE_W];
          end
        end
      end
    end
    if (ec) e_cnt = e_err ? 1 : 0;
    else if (e_err && e_cnt < EMAX) e_cnt++;
    e_ovr = (e_ovr & ~{NUM_CH{oc}}) | (v ? ov : '0);
    e_locked = (m_state == S_LOCK);
    e_phase = m_phase;
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(e_vld));
    chk("locked", 64'(locked), 64'(e_locked));
    chk("phase", 64'(phase), 64'(e_phase));
    chk("sync_err", 64'(sync_err), 64'(e_err));
    chk("sync_err_cnt", 64'(sync_err_cnt), 64'(e_cnt));
    chk("ovr_flag", 64'(ovr_flag), 64'(e_ovr));
    if (e_vld) begin
      chk("out_data", out_data, e_data);
      chk("out_sync", 64'(out_sync), 64'(e_sync));
      if (ramp_chk) chk("ramp_align", 64'(out_data[7:0] % 8'd4), 64'd2);
    end else begin
      chk("out_sync_idle", 64'(out_sync), 64'd0);
    end
  endtask

  task automatic cycle(input bit v, input logic [SPC-1:0] sy, input logic [DW-1:0] d,
                       input logic [NUM_CH-1:0] ov, input bit oc, input bit ec);
    in_valid = v; in_sync = sy; in_data = d; in_ovr = ov; ovr_clear = oc; err_clear = ec;
    @(posedge clk);
    model_step(v, sy, d, ov, oc, ec);
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] mkdata();
    logic [DW-1:0] d;
    if (rnd_data) begin
      d = {$urandom, $urandom};
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < SPC; s++)
          d[(c*SPC+s)*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(rv + s + c * 128);
      rv += SPC;
    end
    return d;
  endfunction

  task automatic send(input logic [SPC-1:0] sy);
    logic [NUM_CH-1:0] ov;
    if (gaps) begin
      repeat ($urandom_range(0, 1)) cycle(0, SPC'($urandom), DW'({$urandom, $urandom}), '0, 0, 0);
    end
    ov = gaps ? NUM_CH'($urandom_range(0, 3) == 0 ? $urandom : 0) : '0;
    cycle(1, sy, mkdata(), ov, 0, 0);
  endtask

  // Sync goes high from 'slot' to the end of the first word of each period, then low.
  task automatic sync_run(input int period, input int slot, input int n_edges);
    logic [SPC-1:0] hi;
    hi = SPC'(4'hF << slot);
    for (int e = 0; e < n_edges; e++)
      for (int w = 0; w < period; w++)
        send(w == 0 ? hi : '0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 0; in_sync = '0; in_data = '0; in_ovr = '0; ovr_clear = 0; err_clear = 0;
    model_reset();
    rv = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    // Ramp data, sync at slot 2 every 64 words: lock on the 5th edge.
    do_reset();
    ramp_chk = 1;
    sync_run(64, 2, 5);
    chk("t1_locked", 64'(locked), 64'd1);
    chk("t1_phase", 64'(phase), 64'd2);
    sync_run(64, 2, 1);
    ramp_chk = 0;

    // Lock at slot 1, then edges move to slot 3.
    do_reset();
    sync_run(16, 1, 5);
    chk("t2_locked", 64'(locked), 64'd1);
    sync_run(16, 3, 1);
    chk("t2_err_cnt", 64'(sync_err_cnt), 64'd1);
    chk("t2_unlocked", 64'(locked), 64'd0);
    sync_run(16, 3, 4);
    chk("t2_relocked", 64'(locked), 64'd1);
    chk("t2_phase", 64'(phase), 64'd3);

    // Sync held low long enough for the period counter to saturate.
    for (int i = 0; i < (1 << TIMEOUT_W); i++) send('0);
    chk("t3_unlocked", 64'(locked), 64'd0);
    chk("t3_phase_held", 64'(phase), 64'd3);
    chk("t3_err_cnt", 64'(sync_err_cnt), 64'd2);
    cycle(1, '0, mkdata(), '0, 0, 1);
    chk("t3_err_clear", 64'(sync_err_cnt), 64'd0);

    // Slot-0 edge detection depends on the previous word's last sample.
    do_reset();
    send(4'b1000);
    send(4'b1111);
    chk("t4_no_edge_phase", 64'(phase), 64'd3);
    send(4'b0000);
    send(4'b0001);
    chk("t4_phase0", 64'(phase), 64'd0);
    for (int i = 0; i < 4; i++) send(4'b0000);

    // Over-range: set wins over a simultaneous clear; clear alone empties.
    cycle(1, '0, mkdata(), 2'b10, 1, 0);
    chk("t5_ovr_set", 64'(ovr_flag), 64'b10);
    cycle(0, '0, '0, '0, 1, 0);
    chk("t5_ovr_clr", 64'(ovr_flag), 64'b00);

    // Random gaps and data, reset mid-acquire, then a full lock with gaps.
    do_reset();
    gaps = 1; rnd_data = 1;
    sync_run(20, 2, 3);
    #2;
    rst_n = 0;
    in_valid = 0; in_sync = '0; in_ovr = '0;
    model_reset();
    #1;
    check_all();
    chk("t6_rst_out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1;
    sync_run(20, 2, 6);
    chk("t6_locked", 64'(locked), 64'd1);
    gaps = 0; rnd_data = 0;
    cycle(0, '0, '0, '0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
